// File: rtl/demux_dispatcher_pkg.sv
// rtl/demux_dispatcher_pkg.sv - shared constants and types for the demux dispatcher (option: DEMUX_DISPATCH_STATS_EN)
package demux_dispatcher_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Pointer starts on the top channel so the first scan lands on channel 0.
    localparam sel_t LAST_SEL_RESET = sel_t'(NUM_CH - 1);

endpackage

// File: rtl/demux_dispatcher_if.sv
// rtl/demux_dispatcher_if.sv - upstream stream, channel control and demux drive bundle
interface demux_dispatcher_if #(
    parameter int DATA_W = 1
);
    import demux_dispatcher_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [NUM_CH-1:0] chan_en;
    logic [NUM_CH-1:0] chan_ready;
    logic [DATA_W-1:0] d_in;
    sel_t              d_sel;
    logic              d_valid;
    logic [31:0]       stats;

    modport master (
        output s_valid, s_data, chan_en, chan_ready,
        input  s_ready, d_in, d_sel, d_valid, stats
    );

    modport slave (
        input  s_valid, s_data, chan_en, chan_ready,
        output s_ready, d_in, d_sel, d_valid, stats
    );

endinterface

// File: rtl/demux_dispatcher_rr_pick.sv
// rtl/demux_dispatcher_rr_pick.sv - round-robin next-channel pick over an enable mask
module demux_dispatcher_rr_pick
    import demux_dispatcher_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  sel_t              last,
    output sel_t              nxt,
    output logic              any
);

    sel_t idx;

    // Scan from farthest to nearest so the nearest enabled channel wins;
    // offset NUM_CH wraps back to last itself for the single-channel case.
    always_comb begin
        nxt = last;
        idx = last;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = last + sel_t'(k);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - round-robin dispatcher feeding the 1-to-4 demux (option: DEMUX_DISPATCH_STATS_EN)
module demux_dispatcher
    import demux_dispatcher_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    demux_dispatcher_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] data_q;
    sel_t              sel_q;
    sel_t              last_q;
    sel_t              nxt;
    logic              any;
    logic              hold;
    logic              drain;
    logic              ready_int;
    logic              accept;

    demux_dispatcher_rr_pick u_rr_pick (
        .mask (bus.chan_en),
        .last (last_q),
        .nxt  (nxt),
        .any  (any)
    );

    assign hold      = (state == ST_HOLD);
    assign drain     = hold && bus.chan_ready[sel_q];
    assign ready_int = any && (!hold || bus.chan_ready[sel_q]);
    assign accept    = bus.s_valid && ready_int;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_HOLD;
            ST_HOLD: if (drain && !accept) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The held word keeps its channel; a mask change only steers the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            last_q <= LAST_SEL_RESET;
        end else if (accept) begin
            data_q <= bus.s_data;
            sel_q  <= nxt;
            last_q <= nxt;
        end else if (drain) begin
            data_q <= '0;
        end
    end

    assign bus.s_ready = ready_int;
    assign bus.d_valid = hold;
    assign bus.d_in    = data_q;
    assign bus.d_sel   = sel_q;

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [7:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (drain) begin
            cnt[sel_q] <= cnt[sel_q] + 8'd1;
        end
    end

    assign bus.stats = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
    assign bus.stats = 32'h0;
`endif

endmodule
